// File: rtl/mem_bank_pkg.sv
// mem_bank_pkg: FSM state encoding and read latency shared by the mem_bank slice.
// RD_LAT tracks the MEM_BANK_OREG_EN build option (output register stage).
package mem_bank_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

`ifdef MEM_BANK_OREG_EN
  localparam int RD_LAT = 2;
`else
  localparam int RD_LAT = 1;
`endif

endpackage

// File: rtl/mem_bank_ram.sv
// mem_bank_ram: single-port byte-write RAM with registered read address.
// No reset on the array or address register so the tools can map it onto block RAM.
module mem_bank_ram #(
  parameter int DP = 1024,
  parameter int DW = 16,
  parameter int IW = 10
) (
  input  logic            clk,
  input  logic            i_en,
  input  logic            i_we,
  input  logic [IW-1:0]   i_addr,
  input  logic [DW-1:0]   i_wdata,
  input  logic [DW/8-1:0] i_be,
  output logic [DW-1:0]   o_rdata
);

  logic [DW-1:0] r_mem [DP];
  logic [IW-1:0] r_addr;

  always_ff @(posedge clk) begin
    if (i_en) begin
      r_addr <= i_addr;
      for (int b = 0; b < DW/8; b++) begin
        if (i_we && i_be[b]) begin
          r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
        end
      end
    end
  end

  assign o_rdata = r_mem[r_addr];

endmodule

// File: rtl/mem_bank.sv
// mem_bank: clearable byte-write memory bank with a one-request-per-cycle port.
// Define MEM_BANK_OREG_EN to add an output register stage (read latency 2).
module mem_bank
  import mem_bank_pkg::*;
#(
  parameter int DP = 1024,
  parameter int DW = 16,
  parameter int AW = 10
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req,
  input  logic            req_we,
  input  logic [AW-1:0]   req_addr,
  input  logic [DW-1:0]   req_wdata,
  input  logic [DW/8-1:0] req_be,
  output logic            req_rdy,
  input  logic            clr_start,
  output logic            busy,
  output logic            rsp_vld,
  output logic [DW-1:0]   rsp_rdata
);

  localparam int IW = (DP > 1) ? $clog2(DP) : 1;
  localparam int BW = DW / 8;

  state_t        r_state;
  logic [AW-1:0] r_clrCnt;
  logic          r_busy;
  logic          r_reqRdy;

  logic          w_clearing;
  logic          w_accept;
  logic          w_inRange;
  logic          w_rdAccept;
  logic          w_ramEn;
  logic          w_ramWe;
  logic [IW-1:0] w_ramAddr;
  logic [DW-1:0] w_ramWdata;
  logic [BW-1:0] w_ramBe;
  logic [DW-1:0] w_ramRdata;

  logic          r_vld1;
  logic          r_zero1;
  logic [DW-1:0] r_hold;
  logic [DW-1:0] w_rdata1;

  assign w_clearing = (r_state == ST_CLEAR);
  assign w_accept   = req && !w_clearing;
  assign w_inRange  = ({1'b0, req_addr} < (AW+1)'(DP));
  assign w_rdAccept = w_accept && !req_we;

  // The clear sequence owns the single RAM port; out-of-range requests never touch it.
  assign w_ramEn    = w_clearing || (w_accept && w_inRange);
  assign w_ramWe    = w_clearing || req_we;
  assign w_ramAddr  = w_clearing ? r_clrCnt[IW-1:0] : req_addr[IW-1:0];
  assign w_ramWdata = w_clearing ? '0 : req_wdata;
  assign w_ramBe    = w_clearing ? '1 : req_be;

  mem_bank_ram #(
    .DP(DP),
    .DW(DW),
    .IW(IW)
  ) u_ram (
    .clk    (clk),
    .i_en   (w_ramEn),
    .i_we   (w_ramWe),
    .i_addr (w_ramAddr),
    .i_wdata(w_ramWdata),
    .i_be   (w_ramBe),
    .o_rdata(w_ramRdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_CLEAR;
      r_clrCnt <= '0;
      r_busy   <= 1'b1;
      r_reqRdy <= 1'b0;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          if (r_clrCnt == AW'(DP - 1)) begin
            r_state  <= ST_READY;
            r_clrCnt <= '0;
            r_busy   <= 1'b0;
            r_reqRdy <= 1'b1;
          end else begin
            r_clrCnt <= r_clrCnt + 1'b1;
          end
        end
        ST_READY: begin
          if (clr_start) begin
            r_state  <= ST_CLEAR;
            r_clrCnt <= '0;
            r_busy   <= 1'b1;
            r_reqRdy <= 1'b0;
          end
        end
        default: begin
          r_state  <= ST_CLEAR;
          r_clrCnt <= '0;
          r_busy   <= 1'b1;
          r_reqRdy <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = r_busy;
  assign req_rdy = r_reqRdy;

  // r_hold keeps the last response stable even if later writes or clears hit the RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld1  <= 1'b0;
      r_zero1 <= 1'b0;
      r_hold  <= '0;
    end else begin
      r_vld1 <= w_rdAccept;
      if (w_rdAccept) begin
        r_zero1 <= !w_inRange;
      end
      if (r_vld1) begin
        r_hold <= w_rdata1;
      end
    end
  end

  assign w_rdata1 = !r_vld1 ? r_hold : (r_zero1 ? '0 : w_ramRdata);

`ifdef MEM_BANK_OREG_EN
  logic          r_vld2;
  logic [DW-1:0] r_rdata2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld2   <= 1'b0;
      r_rdata2 <= '0;
    end else begin
      r_vld2 <= r_vld1;
      if (r_vld1) begin
        r_rdata2 <= w_rdata1;
      end
    end
  end

  assign rsp_vld   = r_vld2;
  assign rsp_rdata = r_rdata2;
`else
  assign rsp_vld   = r_vld1;
  assign rsp_rdata = w_rdata1;
`endif

endmodule

// File: tb/tb_mem_bank.sv
// tb_mem_bank: directed and randomized bench for mem_bank at DP=16, DW=16, AW=5.
// Define MEM_BANK_OREG_EN for both RTL and bench to exercise the registered-output build.
module tb_mem_bank;

  localparam int DP = 16;
  localparam int DW = 16;
  localparam int AW = 5;
`ifdef MEM_BANK_OREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req = 1'b0;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [1:0]    req_be = '0;
  logic          req_rdy;
  logic          clr_start = 1'b0;
  logic          busy;
  logic          rsp_vld;
  logic [DW-1:0] rsp_rdata;

  int checks = 0;
  int errors = 0;
  bit compareEn = 1'b0;

  always #5 clk = ~clk;

  mem_bank #(
    .DP(DP),
    .DW(DW),
    .AW(AW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .req_we   (req_we),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .req_be   (req_be),
    .req_rdy  (req_rdy),
    .clr_start(clr_start),
    .busy     (busy),
    .rsp_vld  (rsp_vld),
    .rsp_rdata(rsp_rdata)
  );

  // Reference model: array contents, remaining clear cycles, and a queue of
  // responses tagged with the cycle in which they must appear.
  typedef struct {
    int          due;
    logic [DW-1:0] data;
  } rsp_t;

  logic [DW-1:0] modelMem [DP];
  rsp_t          rspQ[$];
  int            clearLeft = DP;
  int            cycleCnt = 0;
  logic          expBusy = 1'b1;
  logic          expVld = 1'b0;
  logic [DW-1:0] expRdata = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clearLeft = DP;
      rspQ.delete();
      expBusy  = 1'b1;
      expVld   = 1'b0;
      expRdata = '0;
    end else begin
      cycleCnt++;
      if (clearLeft > 0) begin
        clearLeft--;
        if (clearLeft == 0) begin
          for (int i = 0; i < DP; i++) modelMem[i] = '0;
        end
      end else begin
        if (req) begin
          if (req_we) begin
            if (int'(req_addr) < DP) begin
              for (int b = 0; b < 2; b++) begin
                if (req_be[b]) modelMem[req_addr[3:0]][b*8 +: 8] = req_wdata[b*8 +: 8];
              end
            end
          end else begin
            rspQ.push_back('{cycleCnt + LAT - 1,
                             (int'(req_addr) < DP) ? modelMem[req_addr[3:0]] : '0});
          end
        end
        if (clr_start) clearLeft = DP;
      end
      expBusy = (clearLeft > 0);
      expVld  = 1'b0;
      if (rspQ.size() > 0 && rspQ[0].due == cycleCnt) begin
        expVld   = 1'b1;
        expRdata = rspQ[0].data;
        void'(rspQ.pop_front());
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (compareEn) begin
      checkOutput("busy", 32'(busy), 32'(expBusy));
      checkOutput("req_rdy", 32'(req_rdy), 32'(!expBusy));
      checkOutput("rsp_vld", 32'(rsp_vld), 32'(expVld));
      checkOutput("rsp_rdata", 32'(rsp_rdata), 32'(expRdata));
    end
  end

  task automatic applyStimulus(input logic r, input logic we, input logic [AW-1:0] a,
                               input logic [DW-1:0] d, input logic [1:0] be, input logic c);
    @(negedge clk);
    req       = r;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    req_be    = be;
    clr_start = c;
  endtask

  task automatic readCheck(input string name, input logic [AW-1:0] a, input logic [DW-1:0] exp);
    applyStimulus(1'b1, 1'b0, a, '0, 2'b00, 1'b0);
    repeat (LAT) applyStimulus(1'b0, 1'b0, '0, '0, 2'b00, 1'b0);
    checkOutput({name, "Vld"}, 32'(rsp_vld), 32'd1);
    checkOutput({name, "Data"}, 32'(rsp_rdata), 32'(exp));
  endtask

  // Counts busy cycles from the current falling edge, noting any response seen meanwhile.
  task automatic waitClear(output int cnt, output int vldCnt, output logic [DW-1:0] vData);
    cnt = 0;
    vldCnt = 0;
    vData = '0;
    while (busy === 1'b1 && cnt < 100) begin
      if (rsp_vld === 1'b1) begin
        vldCnt++;
        vData = rsp_rdata;
      end
      cnt++;
      @(negedge clk);
    end
  endtask

  initial begin
    int cnt;
    int vc;
    logic [DW-1:0] vd;

    repeat (3) @(negedge clk);
    compareEn = 1'b1;
    checkOutput("resetBusy", 32'(busy), 32'd1);
    checkOutput("resetRdy", 32'(req_rdy), 32'd0);
    checkOutput("resetVld", 32'(rsp_vld), 32'd0);
    checkOutput("resetRdata", 32'(rsp_rdata), 32'd0);

    rst_n = 1'b1;
    waitClear(cnt, vc, vd);
    checkOutput("initClearLen", 32'(cnt), 32'd16);

    readCheck("rd5", 5'd5, 16'h0000);
    applyStimulus(1'b1, 1'b1, 5'd3, 16'hA55A, 2'b11, 1'b0);
    readCheck("rd3a", 5'd3, 16'hA55A);
    applyStimulus(1'b1, 1'b1, 5'd3, 16'h1234, 2'b01, 1'b0);
    readCheck("rd3b", 5'd3, 16'hA534);
    applyStimulus(1'b1, 1'b1, 5'd20, 16'hFFFF, 2'b11, 1'b0);
    readCheck("rd20", 5'd20, 16'h0000);
    readCheck("rd4", 5'd4, 16'h0000);

    applyStimulus(1'b1, 1'b0, 5'd3, '0, 2'b00, 1'b1);
    applyStimulus(1'b0, 1'b0, '0, '0, 2'b00, 1'b0);
    waitClear(cnt, vc, vd);
    checkOutput("clrLen", 32'(cnt), 32'd16);
    checkOutput("clrRspCount", 32'(vc), 32'd1);
    checkOutput("clrRspData", 32'(vd), 32'hA534);
    readCheck("rd3c", 5'd3, 16'h0000);

    // Reset with a read in flight: no response may survive it.
    applyStimulus(1'b1, 1'b1, 5'd7, 16'hBEEF, 2'b11, 1'b0);
    applyStimulus(1'b1, 1'b0, 5'd7, '0, 2'b00, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("inflightVld", 32'(rsp_vld), (LAT == 1) ? 32'd1 : 32'd0);
    rst_n = 1'b0;
    #1;
    checkOutput("abortVld", 32'(rsp_vld), 32'd0);
    checkOutput("abortRdata", 32'(rsp_rdata), 32'd0);
    checkOutput("abortBusy", 32'(busy), 32'd1);
    @(negedge clk);
    req = 1'b0;
    rst_n = 1'b1;
    waitClear(cnt, vc, vd);
    checkOutput("abortClearLen", 32'(cnt), 32'd16);
    checkOutput("abortNoRsp", 32'(vc), 32'd0);

    // Reset at clear count 7 restarts the full clear.
    applyStimulus(1'b0, 1'b0, '0, '0, 2'b00, 1'b1);
    applyStimulus(1'b0, 1'b0, '0, '0, 2'b00, 1'b0);
    repeat (6) @(negedge clk);
    checkOutput("midClearBusy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("midClearVld", 32'(rsp_vld), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    waitClear(cnt, vc, vd);
    checkOutput("restartClearLen", 32'(cnt), 32'd16);

    // Back-to-back reads.
    applyStimulus(1'b1, 1'b1, 5'd1, 16'h1111, 2'b11, 1'b0);
    applyStimulus(1'b1, 1'b1, 5'd2, 16'h2222, 2'b11, 1'b0);
    applyStimulus(1'b1, 1'b0, 5'd1, '0, 2'b00, 1'b0);
    applyStimulus(1'b1, 1'b0, 5'd2, '0, 2'b00, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      if (k > 1) applyStimulus(1'b0, 1'b0, '0, '0, 2'b00, 1'b0);
      checkOutput($sformatf("b2bVld%0d", k), 32'(rsp_vld),
                  ((k == LAT) || (k == LAT + 1)) ? 32'd1 : 32'd0);
      if (k >= LAT) begin
        checkOutput($sformatf("b2bData%0d", k), 32'(rsp_rdata),
                    (k == LAT) ? 32'h1111 : 32'h2222);
      end
    end

    // Randomized traffic; the compare process checks every cycle.
    for (int n = 0; n < 3000; n++) begin
      logic [AW-1:0] a;
      a = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, 19));
      applyStimulus(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), a,
                    DW'($urandom), 2'($urandom_range(0, 3)),
                    1'($urandom_range(0, 79) == 0));
    end
    applyStimulus(1'b0, 1'b0, '0, '0, 2'b00, 1'b0);
    repeat (LAT + 2) @(negedge clk);

    compareEn = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_bank.md
MEM_BANK -- requirements
Module: mem_bank

Interface
REQ-001 SHALL have parameter DP, default 1024, word depth.
REQ-002 SHALL have parameter DW, default 16, data width; must be a multiple of 8.
REQ-003 SHALL have parameter AW, default 10, address width; 2^AW >= DP.
REQ-004 SHALL have port clk  in  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have port req  in  1  access request.
REQ-007 SHALL have port req_we  in  1  1 = write, 0 = read.
REQ-008 SHALL have port req_addr  in  AW  word address.
REQ-009 SHALL have port req_wdata  in  DW  write data.
REQ-010 SHALL have port req_be  in  DW/8  byte write enables, bit i covers byte i.
REQ-011 SHALL have port req_rdy  out  1  request accepted when req && req_rdy.
REQ-012 SHALL have port clr_start  in  1  start full-array zero clear.
REQ-013 SHALL have port busy  out  1  clear in progress.
REQ-014 SHALL have port rsp_vld  out  1  read data valid pulse.
REQ-015 SHALL have port rsp_rdata  out  DW  read data.

Function
REQ-016 SHALL implement a two-state FSM: CLEAR and READY.
REQ-017 In CLEAR, SHALL write zero to one address per cycle, counting 0 to DP-1; busy=1, req_rdy=0.
REQ-018 SHALL go from CLEAR to READY the cycle after address DP-1 is written; a clear lasts exactly DP cycles.
REQ-019 In READY, SHALL drive req_rdy=1 and busy=0.
REQ-020 clr_start sampled high in READY SHALL enter CLEAR with the counter at 0; clr_start in CLEAR is ignored.
REQ-021 When req and clr_start are high together in READY, the request SHALL be accepted; a read returns pre-clear data.
REQ-022 An accepted write SHALL update only bytes with req_be set, at the accepting clock edge; a write produces no response.
REQ-023 An accepted read SHALL raise rsp_vld for exactly one cycle, 1 cycle after acceptance (latency 1).
REQ-024 A read accepted the cycle after a write to the same address SHALL return the new data.
REQ-025 rsp_rdata SHALL hold its last value until the next read response.
REQ-026 req_addr >= DP SHALL ignore a write; a read SHALL respond normally with rsp_rdata = 0.
REQ-027 SHALL accept back-to-back requests every cycle in READY; the response path has no backpressure.

Reset
REQ-028 rst_n low SHALL force: FSM to CLEAR, counter to 0, rsp_vld=0, rsp_rdata=0, busy=1, req_rdy=0.
REQ-029 Array contents SHALL NOT be reset asynchronously; zeroing is done only by the CLEAR sequence after rst_n rises.
REQ-030 Reset asserted during CLEAR or with a read in flight SHALL abort it; no response is issued, and the clear restarts from address 0.

Configuration
REQ-031 Macro MEM_BANK_OREG_EN defined SHALL add an output register stage: read latency 2, throughput still 1 per cycle, and the reset value of the added stage is 0.
REQ-032 Without MEM_BANK_OREG_EN, read latency SHALL be 1 as in REQ-023.

Structure
REQ-033 Package mem_bank_pkg SHALL hold the FSM state encoding (CLEAR, READY) and the read-latency constant.
REQ-034 The storage array SHALL be a sub-module mem_bank_ram: single port, byte-write, registered-address synchronous read, inferable as BRAM.
REQ-035 The FSM, clear counter, out-of-range check and response pipeline SHALL reside in mem_bank.

Verification (DP=16, DW=16, AW=5)
REQ-036 Release rst_n -> busy=1, req_rdy=0 for 16 cycles; then read addr 5 -> rsp_vld next cycle, rsp_rdata=0x0000.
REQ-037 Write 0xA55A be=2'b11 to addr 3, read addr 3 next cycle -> rsp_rdata=0xA55A; then write 0x1234 be=2'b01 and read addr 3 -> 0xA534.
REQ-038 Write 0xFFFF to addr 20, read addr 20 -> rsp_vld=1, rsp_rdata=0x0000; addr 4 (20 mod 16) is still 0x0000.
REQ-039 Addr 3 = 0xA534; assert clr_start together with a read of addr 3 -> response 0xA534, busy for 16 cycles; re-read addr 3 -> 0x0000.
REQ-040 Assert rst_n low at clear count 7 -> rsp_vld=0 immediately; after release, busy lasts a full 16 cycles.
REQ-041 With MEM_BANK_OREG_EN, back-to-back reads of addr 1 and addr 2 -> rsp_vld at +2 and +3 with the correct data.
